// File: rtl/aes_req_arbiter.sv
// Shares one AES-128 core between two block requesters: round-robin grant,
// one block in flight, single-cycle start, watchdog on the core's done pulse.
//
// state | meaning
// IDLE  | no block in flight; grant the winner, latch its plaintext and id
// ISSUE | one-cycle aes_start, watchdog timer cleared
// WAIT  | waiting for aes_done or watchdog expiry
// RESP  | response held on rsp_* until rsp_ready
module aes_req_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  output logic         aes_start,
  output logic [127:0] aes_din,
  input  logic         aes_done,
  input  logic [127:0] aes_dout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic             timer_hit;
  logic [CNT_W-1:0] timer;
  logic [127:0]     din_q;
  logic [127:0]     rsp_data_q;
  logic             id_q;
  logic             err_q;

  // Both pending: the requester not served last goes next.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign timer_hit  = (timer == TIMER_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    aes_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        aes_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (aes_done || timer_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
      timer      <= '0;
      din_q      <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        din_q <= req1_ready ? req1_data : req0_data;
        id_q  <= req1_ready;
      end

      if (state == ISSUE) begin
        timer <= '0;
      end else if ((state == WAIT) && !aes_done && !timer_hit) begin
        timer <= timer + CNT_W'(1);
      end

      // A done pulse in the expiry cycle still delivers the ciphertext.
      if (state == WAIT) begin
        if (aes_done) begin
          rsp_data_q <= aes_dout;
          err_q      <= 1'b0;
        end else if (timer_hit) begin
          rsp_data_q <= '0;
          err_q      <= 1'b1;
        end
      end

      if ((state == RESP) && rsp_ready) begin
        last_grant <= id_q;
      end
    end
  end

  assign aes_din  = din_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id   = id_q;
  assign rsp_err  = err_q;

  a_one_ready : assert property (@(posedge clock) disable iff (reset)
    !(req0_ready && req1_ready));

  a_din_stable : assert property (@(posedge clock) disable iff (reset)
    (state == WAIT) |-> $stable(aes_din));

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: directed scenarios plus a random phase, checked
// cycle by cycle against a transaction-level model of the arbiter's rules.
module tb_aes_req_arbiter;

  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 8;
  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [127:0] req0_data, req1_data, aes_din, aes_dout, rsp_data;
  logic         aes_start, aes_done, rsp_valid, rsp_ready, rsp_id, rsp_err, busy;

  aes_req_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .aes_start(aes_start), .aes_din(aes_din),
    .aes_done(aes_done), .aes_dout(aes_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clock = ~clock;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  int   core_lat   = 10;
  logic core_mute  = 1'b0;
  int   inject_seq = 0;

  // reference model: at most one block outstanding, plus round-robin memory
  logic         m_out = 1'b0, m_last = 1'b1, m_id = 1'b0, m_fresh = 1'b1, m_err = 1'b0;
  int           m_hs = 0, m_rsp = 0;
  logic [127:0] m_pt = '0, m_data = '0;

  // observed events
  logic         hs0 = 1'b0, hs1 = 1'b0, rsp_fire = 1'b0, prev_rv = 1'b0;
  int           ev_hs_cyc = 0, ev_start_cyc = 0, ev_rsp_cyc = 0, ev_fire_cyc = 0, rsp_count = 0;
  logic         ev_rsp_id = 1'b0, ev_rsp_err = 1'b0;
  logic [127:0] ev_rsp_data = '0;
  logic         obs_grants[$];

  function automatic logic [127:0] core_fn(input logic [127:0] pt);
    if (pt == KAT_PT) return KAT_CT;
    return {pt[95:0], pt[127:96]} ^ 128'hc3a55a3c0f1e2d4b8697a5b4c3d2e1f0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expd);
    n_assert++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  // Core stand-in: done pulse core_lat cycles after start, or never when muted.
  initial begin : core_model
    int           cnt;
    int           seen;
    logic [127:0] pt;
    cnt = 0; seen = 0; pt = '0;
    aes_done = 1'b0;
    aes_dout = '0;
    forever begin
      @(negedge clock);
      aes_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          aes_done = 1'b1;
          aes_dout = core_fn(pt);
        end
      end else if (seen != inject_seq) begin
        seen     = inject_seq;
        aes_done = 1'b1;
        aes_dout = rnd128();
      end
      if (aes_start === 1'b1) begin
        pt  = aes_din;
        cnt = core_mute ? 0 : core_lat;
      end
    end
  end

  // One clock: check outputs at the falling edge, advance the model, step past the rising edge.
  task automatic cycle();
    logic exp_r0, exp_r1, exp_rv;
    @(negedge clock);
    hs0 = 1'b0; hs1 = 1'b0; rsp_fire = 1'b0;
    if (reset === 1'b0) begin
      exp_r0 = !m_out && req0_valid && (!req1_valid || m_last);
      exp_r1 = !m_out && req1_valid && (!req0_valid || !m_last);
      exp_rv = m_out && (cyc >= m_rsp);
      chk("req0_ready", 128'(req0_ready), 128'(exp_r0));
      chk("req1_ready", 128'(req1_ready), 128'(exp_r1));
      chk("one_ready", 128'(req0_ready & req1_ready), 128'(0));
      chk("busy", 128'(busy), 128'(m_out && (cyc > m_hs)));
      chk("aes_start", 128'(aes_start), 128'(m_out && (cyc == m_hs + 1)));
      chk("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
      if (exp_rv) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_id", 128'(rsp_id), 128'(m_id));
        chk("rsp_err", 128'(rsp_err), 128'(m_err));
      end
      if (m_out && (cyc > m_hs) && (cyc < m_rsp)) chk("aes_din", aes_din, m_pt);
      if (m_fresh) begin
        chk("aes_din_rst", aes_din, '0);
        chk("rsp_data_rst", rsp_data, '0);
        chk("rsp_id_rst", 128'(rsp_id), 128'(0));
        chk("rsp_err_rst", 128'(rsp_err), 128'(0));
      end

      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (hs0 || hs1) begin
        ev_hs_cyc = cyc;
        obs_grants.push_back(hs1);
      end
      if (aes_start === 1'b1) ev_start_cyc = cyc;
      if (rsp_valid && !prev_rv) begin
        ev_rsp_cyc  = cyc;
        ev_rsp_data = rsp_data;
        ev_rsp_id   = rsp_id;
        ev_rsp_err  = rsp_err;
        rsp_count++;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_fire    = 1'b1;
        ev_fire_cyc = cyc;
      end

      if (m_out && (cyc == m_hs + 1)) begin
        if (!core_mute && (core_lat <= TIMEOUT)) begin
          m_rsp  = cyc + core_lat + 1;
          m_data = core_fn(m_pt);
          m_err  = 1'b0;
        end else begin
          m_rsp  = cyc + TIMEOUT + 1;
          m_data = '0;
          m_err  = 1'b1;
        end
      end
      if (exp_rv && rsp_ready) begin
        m_out  = 1'b0;
        m_last = m_id;
      end else if (exp_r0 || exp_r1) begin
        m_out   = 1'b1;
        m_hs    = cyc;
        m_id    = exp_r1;
        m_pt    = exp_r1 ? req1_data : req0_data;
        m_rsp   = 1 << 30;
        m_fresh = 1'b0;
      end
    end
    prev_rv = rsp_valid;
    @(posedge clock);
    #1;
    if (reset === 1'b1) begin
      m_out   = 1'b0;
      m_last  = 1'b1;
      m_fresh = 1'b1;
    end
    cyc++;
  endtask

  task automatic wait_hs(input string tag, input int budget);
    int n;
    n = 0; hs0 = 1'b0; hs1 = 1'b0;
    while (!(hs0 || hs1) && (n < budget)) begin
      cycle();
      n++;
    end
    chk(tag, 128'(hs0 || hs1), 128'(1));
  endtask

  task automatic wait_rv(input string tag, input int budget);
    int n;
    n = 0;
    while (!prev_rv && (n < budget)) begin
      cycle();
      n++;
    end
    chk(tag, 128'(prev_rv), 128'(1));
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n;
    n = 0; rsp_fire = 1'b0;
    while (!rsp_fire && (n < budget)) begin
      cycle();
      n++;
    end
    chk(tag, 128'(rsp_fire), 128'(1));
  endtask

  initial begin : stim
    int           n_hs;
    int           n;
    int           rc;
    logic         g;
    logic [127:0] pt;

    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;

    // reset, then quiet inputs
    repeat (3) cycle();
    reset = 1'b0;
    repeat (20) cycle();

    // known-answer block from requester 0
    core_lat = 10; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = KAT_PT;
    wait_hs("t2_hs", 5);
    req0_valid = 1'b0;
    wait_rsp("t2_rsp", 40);
    chk("t2_start_lat", 128'(ev_start_cyc - ev_hs_cyc), 128'(1));
    chk("t2_rsp_lat", 128'(ev_rsp_cyc - ev_start_cyc), 128'(11));
    chk("t2_data", ev_rsp_data, KAT_CT);
    chk("t2_id", 128'(ev_rsp_id), 128'(0));
    chk("t2_err", 128'(ev_rsp_err), 128'(0));

    // both requesters busy from reset: grants alternate starting with 0
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    obs_grants.delete();
    req0_valid = 1'b1; req0_data = rnd128();
    req1_valid = 1'b1; req1_data = rnd128();
    n_hs = 0; n = 0;
    while ((n_hs < 4) && (n < 200)) begin
      core_lat = $urandom_range(1, 8);
      cycle();
      n++;
      if (hs0) begin n_hs++; req0_data = rnd128(); end
      if (hs1) begin n_hs++; req1_data = rnd128(); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_hs_count", 128'(n_hs), 128'(4));
    wait_rsp("t3_last_rsp", 40);
    for (int i = 0; i < 4; i++) begin
      g = (i < obs_grants.size()) ? obs_grants[i] : 1'bx;
      chk("t3_grant_order", 128'(g), 128'(i % 2));
    end

    // silent core: watchdog expiry, then stray done pulses are ignored
    core_mute = 1'b1; rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_data = rnd128();
    wait_hs("t4_hs", 5);
    req1_valid = 1'b0;
    wait_rv("t4_rv", 100);
    chk("t4_rsp_lat", 128'(ev_rsp_cyc - ev_start_cyc), 128'(TIMEOUT + 1));
    chk("t4_err", 128'(ev_rsp_err), 128'(1));
    chk("t4_data", ev_rsp_data, '0);
    chk("t4_id", 128'(ev_rsp_id), 128'(1));
    inject_seq++;
    repeat (3) cycle();
    rsp_ready = 1'b1;
    wait_rsp("t4_rsp", 5);
    inject_seq++;
    repeat (5) cycle();
    core_mute = 1'b0;

    // done exactly at the watchdog limit wins; one cycle later it does not
    for (int lat = TIMEOUT; lat <= TIMEOUT + 1; lat++) begin
      core_lat = lat;
      pt = rnd128();
      req0_valid = 1'b1; req0_data = pt;
      wait_hs("t4b_hs", 5);
      req0_valid = 1'b0;
      wait_rsp("t4b_rsp", 100);
      chk("t4b_rsp_lat", 128'(ev_rsp_cyc - ev_start_cyc), 128'(TIMEOUT + 1));
      chk("t4b_err", 128'(ev_rsp_err), 128'(lat > TIMEOUT));
      chk("t4b_data", ev_rsp_data, (lat > TIMEOUT) ? '0 : core_fn(pt));
      repeat (2) cycle();
    end

    // back-pressure in RESP while requester 1 waits
    core_lat = 6; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = rnd128();
    wait_hs("t5_hs0", 5);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = rnd128();
    wait_rv("t5_rv", 20);
    repeat (5) cycle();
    rsp_ready = 1'b1;
    cycle();
    chk("t5_fire", 128'(rsp_fire), 128'(1));
    cycle();
    chk("t5_req1_hs", 128'(hs1), 128'(1));
    chk("t5_hs_after_fire", 128'(ev_hs_cyc - ev_fire_cyc), 128'(1));
    req1_valid = 1'b0;
    wait_rsp("t5_rsp1", 20);

    // reset while waiting on the core; the late done is dropped
    core_lat = 10;
    req0_valid = 1'b1; req0_data = rnd128();
    wait_hs("t6_hs", 5);
    req0_valid = 1'b0;
    repeat (7) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    rc = rsp_count;
    repeat (8) cycle();
    chk("t6_no_rsp", 128'(rsp_count - rc), 128'(0));
    core_lat = 5;
    pt = rnd128();
    req0_valid = 1'b1; req0_data = pt;
    wait_hs("t6_hs2", 5);
    req0_valid = 1'b0;
    wait_rsp("t6_rsp", 20);
    chk("t6_err", 128'(ev_rsp_err), 128'(0));
    chk("t6_data", ev_rsp_data, core_fn(pt));

    // random traffic
    for (int k = 0; k < 600; k++) begin
      core_lat  = $urandom_range(1, 20);
      core_mute = ($urandom_range(0, 40) == 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (!req0_valid && ($urandom_range(0, 3) == 0)) begin
        req0_valid = 1'b1; req0_data = rnd128();
      end
      if (!req1_valid && ($urandom_range(0, 3) == 0)) begin
        req1_valid = 1'b1; req1_data = rnd128();
      end
      cycle();
      if (hs0) begin req0_valid = 1'($urandom_range(0, 1)); req0_data = rnd128(); end
      if (hs1) begin req1_valid = 1'($urandom_range(0, 1)); req1_data = rnd128(); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    core_mute = 1'b0; rsp_ready = 1'b1;
    repeat (100) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
Name: aes_req_arbiter

Overview:
- Shares one AES-128 encryption core between two 128-bit block requesters. Round-robin arbitration, one block in flight at a time.
- Issues a single-cycle start to the core and waits for its done pulse, with a watchdog timeout.
- Returns the ciphertext tagged with the requester id and an error flag.
- Sits between the bus-slave front ends (plaintext/ciphertext word FIFOs) and the AES core.

Parameters:
- TIMEOUT, 64, maximum WAIT cycles before the block is declared failed; legal range 2..2^CNT_W.
- CNT_W, 8, watchdog counter width.

Ports:
- clock  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  requester 0 has a block.
- req0_data  in  128  requester 0 plaintext.
- req0_ready  out  1  requester 0 block accepted this cycle.
- req1_valid  in  1  requester 1 has a block.
- req1_data  in  128  requester 1 plaintext.
- req1_ready  out  1  requester 1 block accepted this cycle.
- aes_start  out  1  one-cycle start pulse to the core.
- aes_din  out  128  plaintext to the core; held stable from ISSUE until leaving WAIT.
- aes_done  in  1  core result valid, single-cycle pulse.
- aes_dout  in  128  core ciphertext.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  128  ciphertext; 0 on error.
- rsp_id  out  1  requester that owns the response.
- rsp_err  out  1  1 = watchdog timeout.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset values: state IDLE, last_grant=1 (so requester 0 wins first), timer=0.
  - All outputs 0: reqN_ready, aes_start, aes_din, rsp_valid, rsp_data, rsp_id, rsp_err, busy.
  - Reset asserted in any state returns to IDLE next edge and drops any in-flight block; no response is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant is combinational. If only one reqN_valid, grant that requester. If both valid, grant !last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. Only one ready can be high per cycle.
  - On handshake: latch reqN_data into aes_din, latch id, then go to ISSUE.
  - No valid inputs: stay in IDLE.
- ISSUE: aes_start=1 for exactly this cycle; timer cleared; next state WAIT.
- WAIT:
  - If aes_done: latch aes_dout into rsp_data, set rsp_err=0, go to RESP.
  - Else if timer==TIMEOUT-1: set rsp_data=0, rsp_err=1, go to RESP.
  - Else timer+1.
  - aes_done wins over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid=1; rsp_data/rsp_id/rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: last_grant=id, go to IDLE.
  - No request is accepted while in RESP.
- aes_done outside WAIT is ignored; aes_dout is then not sampled.
- Latency: handshake at cycle T; aes_start at T+1; done at cycle D; rsp_valid at D+1.
  - Timeout case: rsp_valid at (T+1)+TIMEOUT+1.
  - With rsp_ready tied high, the next handshake is at earliest D+2.
- Fairness: with both requesters continuously valid, grants strictly alternate. A single active requester is served back-to-back without waiting on the idle one.
- Timer is CNT_W bits. It never wraps, because it is compared against TIMEOUT-1 ≤ 2^CNT_W-1.

Test Plan:
1. Reset held 3 cycles, then released with all inputs 0 → all outputs 0, busy=0, reqN_ready=0 for 20 cycles.
2. Setup: core model pulses done 10 cycles after start and returns 69c4e0d86a7b0430d8cdb78070b4c55a for 00112233445566778899aabbccddeeff. Stimulus: req0 alone sends that plaintext. → aes_start exactly one cycle after handshake; rsp_valid 11 cycles after start; rsp_id=0, rsp_err=0, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
3. req0 and req1 both held valid for 4 transactions, rsp_ready=1 → grant order 0,1,0,1; each rsp_id matches its granted requester; never both ready in a cycle.
4. Core model never asserts done, TIMEOUT=64 → rsp_valid at start+65; rsp_err=1, rsp_data=0. A done pulse then injected in RESP/IDLE has no effect.
5. rsp_ready held 0 for 5 cycles in RESP while req1_valid=1 → rsp_data/rsp_id/rsp_err stable; req1_ready=0 throughout; req1 handshake occurs the cycle after rsp_ready rises.
6. Reset pulsed during WAIT, core done arrives 3 cycles later → state IDLE, no rsp_valid; next req0 block processed normally with rsp_err=0.
